ft_nmr_monitor: RTL

//  N-modular-redundancy successor to the dual-lockstep fault-tolerance block. Compares register-file

---
 rtl/ft_nmr_monitor_if.sv | 25 ++
 rtl/ft_nmr_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ft_nmr_monitor_if.sv
// Writeback bus from the replicated cores into the NMR monitor and the committed write out of it.
// The master modport is the core/bench side; the slave modport is the monitor side.
interface ft_nmr_monitor_if #(
    parameter int NUM_CORES  = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) ();
    logic                            valid_instr_i;
    logic [NUM_CORES-1:0]            we_i;
    logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_CORES*DATA_WIDTH-1:0] data_i;
    logic                            commit_we_o;
    logic [ADDR_WIDTH-1:0]           commit_addr_o;
    logic [DATA_WIDTH-1:0]           commit_data_o;

    modport master (
        output valid_instr_i, we_i, addr_i, data_i,
        input  commit_we_o, commit_addr_o, commit_data_o
    );

    modport slave (
        input  valid_instr_i, we_i, addr_i, data_i,
        output commit_we_o, commit_addr_o, commit_data_o
    );
endinterface

// File: rtl/ft_nmr_monitor.sv
// N-modular-redundancy writeback monitor: votes on per-core (we,addr,data) tuples, commits the agreed
// tuple, flags dissenting cores and sequences core reset/recovery with retry and timeout limits.
module ft_nmr_monitor #(
    parameter int NUM_CORES     = 3,
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_RETRY     = 3,
    parameter int RECOV_TIMEOUT = 64,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 done_i,
    ft_nmr_monitor_if.slave      wb,
    output logic [NUM_CORES-1:0] faulty_mask_o,
    output logic                 reset_cores_o,
    output logic                 load_pc_o,
    output logic                 recover_o,
    output logic                 recovering_o,
    output logic                 fatal_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int CNT_W   = $clog2(NUM_CORES + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TIMER_W = (RECOV_TIMEOUT > 1) ? $clog2(RECOV_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]   MAJ_THRESH  = CNT_W'(NUM_CORES / 2);
    localparam logic [CNT_W-1:0]   ALL_CORES   = CNT_W'(NUM_CORES);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(RECOV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESET,
        ST_RECOVER,
        ST_FATAL
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_tuple_t;

    wb_tuple_t            tuple [NUM_CORES];
    logic [CNT_W-1:0]     agree_cnt [NUM_CORES];
    wb_tuple_t            voted;
    logic                 winner_found;
    logic                 unanimous;
    logic [NUM_CORES-1:0] dissent;

    state_e                state_q, state_d;
    logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [NUM_CORES-1:0]  faulty_mask_q, faulty_mask_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  commit_we_q, commit_we_d;
    logic [ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;
    logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;
    logic                  reset_cores_q, reset_cores_d;
    logic                  load_pc_q, load_pc_d;
    logic                  recover_q, recover_d;
    logic                  recovering_q, recovering_d;
    logic                  fatal_q, fatal_d;

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            tuple[k].we   = wb.we_i[k];
            tuple[k].addr = wb.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            tuple[k].data = wb.data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Each core counts how many cores (itself included) present an identical tuple; the first core
    // whose count is a strict majority supplies the voted tuple. With two cores only unanimity wins.
    always_comb begin
        winner_found = 1'b0;
        voted        = '0;
        dissent      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            agree_cnt[i] = '0;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (tuple[i] == tuple[j]) begin
                    agree_cnt[i] = agree_cnt[i] + 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!winner_found && (agree_cnt[i] > MAJ_THRESH)) begin
                winner_found = 1'b1;
                voted        = tuple[i];
            end
        end
        unanimous = (agree_cnt[0] == ALL_CORES);
        for (int i = 0; i < NUM_CORES; i++) begin
            dissent[i] = (tuple[i] != voted);
        end
    end

    // NOTE: every variable gets its hold/idle value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        retry_cnt_d   = retry_cnt_q;
        timer_d       = timer_q;
        faulty_mask_d = faulty_mask_q;
        err_count_d   = err_count_q;
        commit_we_d   = 1'b0;
        commit_addr_d = commit_addr_q;
        commit_data_d = commit_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wb.valid_instr_i && winner_found) begin
                    commit_we_d   = voted.we;
                    commit_addr_d = voted.addr;
                    commit_data_d = voted.data;
                end
                if (wb.valid_instr_i && unanimous) begin
                    retry_cnt_d = '0;
                end
                if (wb.valid_instr_i && !unanimous) begin
                    if (winner_found) faulty_mask_d = faulty_mask_q | dissent;
                    if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                    if (retry_cnt_q == RETRY_LIMIT) begin
                        state_d = ST_FATAL;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = ST_RESET;
                    end
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESET: begin
                state_d = ST_RECOVER;
                timer_d = '0;
            end
            ST_RECOVER: begin
                timer_d = timer_q + 1'b1;
                if (done_i) begin
                    faulty_mask_d = '0;
                    state_d       = enable_i ? ST_RUN : ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_FATAL;
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Control outputs are decoded from the next state so the flops line up with state_q.
        reset_cores_d = (state_d == ST_RESET);
        load_pc_d     = (state_d == ST_RESET);
        recover_d     = (state_d == ST_RECOVER);
        recovering_d  = (state_d == ST_RESET) || (state_d == ST_RECOVER);
        fatal_d       = (state_d == ST_FATAL);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            retry_cnt_q   <= '0;
            timer_q       <= '0;
            faulty_mask_q <= '0;
            err_count_q   <= '0;
            commit_we_q   <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= '0;
            reset_cores_q <= 1'b0;
            load_pc_q     <= 1'b0;
            recover_q     <= 1'b0;
            recovering_q  <= 1'b0;
            fatal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            retry_cnt_q   <= retry_cnt_d;
            timer_q       <= timer_d;
            faulty_mask_q <= faulty_mask_d;
            err_count_q   <= err_count_d;
            commit_we_q   <= commit_we_d;
            commit_addr_q <= commit_addr_d;
            commit_data_q <= commit_data_d;
            reset_cores_q <= reset_cores_d;
            load_pc_q     <= load_pc_d;
            recover_q     <= recover_d;
            recovering_q  <= recovering_d;
            fatal_q       <= fatal_d;
        end
    end

    assign wb.commit_we_o   = commit_we_q;
    assign wb.commit_addr_o = commit_addr_q;
    assign wb.commit_data_o = commit_data_q;
    assign faulty_mask_o    = faulty_mask_q;
    assign reset_cores_o    = reset_cores_q;
    assign load_pc_o        = load_pc_q;
    assign recover_o        = recover_q;
    assign recovering_o     = recovering_q;
    assign fatal_o          = fatal_q;
    assign err_count_o      = err_count_q;

endmodule
